accum: RTL
==========

ACCUM -- requirements
Module: accum

Interface
REQ-001 SHALL have parameter DIN, default 16: width of the din value field.
REQ-002 SHALL have parameter DIN_SIGNED, default 0: 1 means the value is two's complement, 0 means unsigned.
REQ-003 SHALL have parameter DOUT, default 24: accumulator and result width; DOUT >= DIN is required, and elaboration SHALL fail otherwise.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port din, dti_s_if.consumer, DIN+1 bits: data[DIN] is eot (last element of a transaction), data[DIN-1:0] is the value.
REQ-007 Port dout, dti_s_if.producer, DOUT+1 bits: data[DOUT] is ovf, data[DOUT-1:0] is the transaction sum.

Function
REQ-008 SHALL implement an FSM with two states: ACC (accepting input) and OUT (holding a result).
REQ-009 din.ready SHALL be 1 exactly in ACC; dout.valid SHALL be 1 exactly in OUT; neither depends combinationally on the other side.
REQ-010 Value extension to DOUT bits: sign-extend when DIN_SIGNED=1, zero-extend otherwise.
REQ-011 In ACC, on a din handshake with eot=0: acc <= acc + ext(value), modulo 2^DOUT.
REQ-012 In ACC, on a din handshake with eot=1: the result register SHALL load acc + ext(value); acc SHALL clear to 0; the FSM SHALL move to OUT.
REQ-013 ovf SHALL be a sticky per-transaction flag, set by any addition in the transaction (including the eot addition) that overflows DOUT bits.
REQ-014 Overflow definition: unsigned, carry out of bit DOUT-1; signed, both operands the same sign and the sum sign different.
REQ-015 ovf SHALL clear together with acc when the eot beat is accepted.
REQ-016 In OUT, dout.data SHALL stay stable until dout.ready=1; on that handshake the FSM SHALL return to ACC.
REQ-017 Latency: dout.valid SHALL rise on the first clock edge after the eot handshake.
REQ-018 Throughput: one din beat per cycle inside a transaction, plus at least one bubble cycle per transaction.
REQ-019 A single-beat transaction (first beat has eot=1) SHALL produce ext(value) with ovf=0.
REQ-020 din.valid=0 in ACC SHALL leave acc and ovf unchanged; no input is accepted while in OUT.

Reset
REQ-021 While rst=0: state=ACC, acc=0, ovf=0, result register=0, dout.valid=0, din.ready=1 on the first edge after release.
REQ-022 Reset mid-transaction or in OUT SHALL discard the partial sum and any pending result immediately and asynchronously.

Structure
REQ-023 The FSM state enum (ACC, OUT) SHALL live in shared package accum_pkg; widths SHALL be derived locally from parameters.
REQ-024 No sub-module: the block is a single module with a registered result, so no separate output buffer is needed.

Verification
REQ-025 Unsigned DIN=8, DOUT=12: beats 10, 20, 30(eot), dout.ready=1 -> one dout of sum=60, ovf=0 one cycle after the eot beat; din.ready=0 during that cycle.
REQ-026 Unsigned DIN=8, DOUT=8: beats 200, 100(eot) -> sum=44, ovf=1; the next transaction 5(eot) -> sum=5, ovf=0.
REQ-027 Signed DIN=8, DOUT=10: beats -3, -5, 2(eot) -> sum=10'h3FA (-6), ovf=0; signed beats 127×5 with DOUT=8 -> ovf=1.
REQ-028 Backpressure: dout.ready held 0 for 5 cycles after the result -> dout.data stable, din.ready=0, and no din beat accepted until the dout handshake.
REQ-029 Reset: assert rst=0 after beats 7, 9 (no eot), release, then send 4(eot) -> sum=4, ovf=0, with no stale output emitted.
REQ-030 Random valid/ready stall stress over 1000 transactions against a reference-model scoreboard -> every sum and ovf matches, with no lost or duplicated outputs.

Source files
------------

// File: rtl/accum_pkg.sv
// ---------------------------------------------------------------------------
// accum_pkg -- shared declarations for the transaction accumulator.
//
// Contents:
//   state_e       two-state controller encoding (ACC accepting, OUT holding)
//   add_overflow  overflow decision for one DOUT-bit addition, given the
//                 operand/sum sign bits and the carry out of the top bit
//
// Widths are not fixed here. Every user derives its own widths from its
// parameters.
// ---------------------------------------------------------------------------
package accum_pkg;

  typedef enum logic {
    ACC = 1'b0,  // accepting input beats
    OUT = 1'b1   // holding a finished result for the consumer
  } state_e;

  // Unsigned: the carry out of the top bit means the sum wrapped.
  // Signed: the sum wrapped if both operands have the same sign and the sum
  // has the other sign.
  function automatic logic add_overflow(
    input logic is_signed,
    input logic a_msb,
    input logic b_msb,
    input logic s_msb,
    input logic carry
  );
    return is_signed ? ((a_msb == b_msb) && (s_msb != a_msb)) : carry;
  endfunction

endpackage : accum_pkg

// File: rtl/dti_s_if.sv
// ---------------------------------------------------------------------------
// dti_s_if -- valid/ready streaming interface carrying a W-bit data word.
//
// Signals:
//   valid  producer -> consumer, data is meaningful this cycle
//   ready  consumer -> producer, consumer takes data this cycle
//   data   producer -> consumer, W-bit payload
// A beat transfers on a rising clock edge where valid and ready are both 1.
//
// Modports:
//   producer  drives valid/data, observes ready
//   consumer  observes valid/data, drives ready
// ---------------------------------------------------------------------------
interface dti_s_if #(
  parameter int W = 1
);

  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);

endinterface : dti_s_if

// File: rtl/accum.sv
// ---------------------------------------------------------------------------
// accum -- sums the values of a stream of beats. Each transaction ends with a
// beat that has eot set. The block then presents the sum and a sticky
// overflow flag as a single output beat.
//
// Parameters:
//   DIN         width of the input value field
//   DIN_SIGNED  1: values are two's complement (sign-extended)
//               0: values are unsigned (zero-extended)
//   DOUT        accumulator/result width, must be >= DIN
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   din   consumer, DIN+1 bits: data[DIN] = eot, data[DIN-1:0] = value
//   dout  producer, DOUT+1 bits: data[DOUT] = ovf, data[DOUT-1:0] = sum
//
// Behaviour:
//   ACC: din.ready = 1. Each accepted beat adds ext(value) to acc, and ovf
//        records any wrap. The eot beat loads sum/ovf into the result
//        register, clears acc/ovf, and moves to OUT.
//   OUT: dout.valid = 1 with a stable registered result. The dout
//        handshake returns to ACC.
// din.ready and dout.valid depend only on the state. Neither has a
// combinational path from the other side's handshake signals.
// ---------------------------------------------------------------------------
module accum
  import accum_pkg::*;
#(
  parameter int DIN        = 16,
  parameter bit DIN_SIGNED = 1'b0,
  parameter int DOUT       = 24
) (
  input logic        clk,
  input logic        rst,
  dti_s_if.consumer  din,
  dti_s_if.producer  dout
);

  // The accumulator must be able to hold at least one full input value.
  if (DOUT < DIN) begin : g_width_check
    $error("accum: DOUT (%0d) must be >= DIN (%0d)", DOUT, DIN);
  end

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  state_e          state;
  state_e          state_nxt;

  logic [DIN-1:0]  value;
  logic            eot;
  logic            sign_bit;
  logic [DOUT-1:0] ext;

  logic [DOUT-1:0] acc;
  logic            acc_ovf;
  logic [DOUT-1:0] sum;
  logic            carry;
  logic            add_ovf;

  logic [DOUT-1:0] res_sum;
  logic            res_ovf;

  logic            din_fire;

  // -------------------------------------------------------------------------
  // Input field split and extension to DOUT bits
  // -------------------------------------------------------------------------
  assign value    = din.data[DIN-1:0];
  assign eot      = din.data[DIN];
  assign sign_bit = DIN_SIGNED ? value[DIN-1] : 1'b0;

  // A loop is used because the extension can be zero bits wide
  // (DOUT == DIN), and a constant part-select could not express that.
  always_comb begin
    ext            = '0;
    ext[DIN-1:0]   = value;
    for (int i = DIN; i < DOUT; i++) begin
      ext[i] = sign_bit;
    end
  end

  // -------------------------------------------------------------------------
  // Adder with overflow detection
  // -------------------------------------------------------------------------
  assign {carry, sum} = {1'b0, acc} + {1'b0, ext};
  assign add_ovf      = add_overflow(DIN_SIGNED, acc[DOUT-1], ext[DOUT-1],
                                     sum[DOUT-1], carry);

  // din.ready is 1 only in ACC, so the input handshake is "in ACC and valid".
  assign din_fire = (state == ACC) && din.valid;

  // -------------------------------------------------------------------------
  // Controller: state register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) assignments, so every register
  // samples values from before the edge, whatever the order of the processes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Controller: next state and handshake outputs
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first. Otherwise any path
  // that skips an assignment would infer a latch.
  always_comb begin
    state_nxt  = state;
    din.ready  = 1'b0;
    dout.valid = 1'b0;
    unique case (state)
      ACC: begin
        din.ready = 1'b1;
        if (din.valid && eot) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        dout.valid = 1'b1;
        if (dout.ready) begin
          state_nxt = ACC;
        end
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Running sum and sticky overflow of the open transaction
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
    end else if (din_fire) begin
      if (eot) begin
        // The transaction closes. The next one starts from a clean slate.
        acc     <= '0;
        acc_ovf <= 1'b0;
      end else begin
        acc     <= sum;
        acc_ovf <= acc_ovf | add_ovf;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Result register: loaded only by the eot beat. It holds while in OUT, so
  // dout.data stays stable under backpressure.
  // -------------------------------------------------------------------------
  // NOTE: the result register is reset as well. A reset in OUT must not leave
  // a stale sum that could look like valid data after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_sum <= '0;
      res_ovf <= 1'b0;
    end else if (din_fire && eot) begin
      res_sum <= sum;
      res_ovf <= acc_ovf | add_ovf;
    end
  end

  assign dout.data = {res_ovf, res_sum};

endmodule : accum
